// File: rtl/button_color_sel.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | button_color_sel: debounced push-button that steps/resets a colour    |
// | index and drives one-hot RGB LED enables.       Rev 1.0               |
// +-----------------------------------------------------------------------+
module button_color_sel #(
  parameter int DEBOUNCE_CYCLES = 120000,
  parameter int LONG_CYCLES     = 12000000,
  parameter int NUM_COLORS      = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_n,
  output logic [2:0] color,
  output logic       press_pulse,
  output logic       long_pulse,
  output logic       btn_level,
  output logic       red_led,
  output logic       green_led,
  output logic       blue_led
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES);
  localparam int HW = $clog2(LONG_CYCLES);
  localparam logic [DW-1:0] D_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] H_LAST = HW'(LONG_CYCLES - 1);
  localparam logic [2:0]    C_LAST = 3'(NUM_COLORS - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_HOLD  = 2'd1;
  localparam logic [1:0] ST_LATCH = 2'd2;

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          s;
  logic [DW-1:0] dcnt_q, dcnt_d;
  logic          btn_level_q, btn_level_d;
  logic [1:0]    state_q, state_d;
  logic [HW-1:0] hcnt_q, hcnt_d;
  logic [2:0]    color_q, color_d;
  logic          press_q, press_d;
  logic          long_q, long_d;
  logic          red_q, red_d;
  logic          green_q, green_d;
  logic          blue_q, blue_d;

  // Synchroniser idles released (1) so reset never looks like a press.
  always_comb begin
    sync1_d = btn_n;
    sync2_d = sync1_q;
  end

  assign s = ~sync2_q;

  always_comb begin
    dcnt_d      = dcnt_q;
    btn_level_d = btn_level_q;
    if (s == btn_level_q) begin
      dcnt_d = '0;
    end else if (dcnt_q == D_LAST) begin
      btn_level_d = s;
      dcnt_d      = '0;
    end else begin
      dcnt_d = dcnt_q + 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    hcnt_d  = hcnt_q;
    color_d = color_q;
    press_d = 1'b0;
    long_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (btn_level_q) begin
          state_d = ST_HOLD;
          hcnt_d  = '0;
        end
      end
      ST_HOLD: begin
        if (!btn_level_q) begin
          press_d = 1'b1;
          color_d = (color_q == C_LAST) ? 3'd0 : color_q + 3'd1;
          state_d = ST_IDLE;
        end else if (hcnt_q == H_LAST) begin
          long_d  = 1'b1;
          color_d = 3'd0;
          state_d = ST_LATCH;
        end else begin
          hcnt_d = hcnt_q + 1'b1;
        end
      end
      ST_LATCH: begin
        // Held after a long press: release is silent, no auto-repeat.
        if (!btn_level_q) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    red_d   = (color_d == 3'd0);
    green_d = (color_d == 3'd1);
    blue_d  = (color_d == 3'd2);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      dcnt_q      <= '0;
      btn_level_q <= 1'b0;
      state_q     <= ST_IDLE;
      hcnt_q      <= '0;
      color_q     <= 3'd0;
      press_q     <= 1'b0;
      long_q      <= 1'b0;
      red_q       <= 1'b1;
      green_q     <= 1'b0;
      blue_q      <= 1'b0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      dcnt_q      <= dcnt_d;
      btn_level_q <= btn_level_d;
      state_q     <= state_d;
      hcnt_q      <= hcnt_d;
      color_q     <= color_d;
      press_q     <= press_d;
      long_q      <= long_d;
      red_q       <= red_d;
      green_q     <= green_d;
      blue_q      <= blue_d;
    end
  end

  assign color       = color_q;
  assign press_pulse = press_q;
  assign long_pulse  = long_q;
  assign btn_level   = btn_level_q;
  assign red_led     = red_q;
  assign green_led   = green_q;
  assign blue_led    = blue_q;

endmodule
`default_nettype wire

// File: tb/tb_button_color_sel.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_button_color_sel: scoreboard bench for button_color_sel.  Rev 1.0  |
// +-----------------------------------------------------------------------+
module tb_button_color_sel;

  localparam int D  = 4;
  localparam int L  = 20;
  localparam int NC = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_n = 1'b1;
  logic [2:0] color;
  logic       press_pulse, long_pulse, btn_level;
  logic       red_led, green_led, blue_led;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  int exp_color = 0;

  typedef struct {
    bit         is_long;
    int         cyc;
    logic [2:0] color;
  } ev_t;

  ev_t sb[$];

  button_color_sel #(
    .DEBOUNCE_CYCLES(D),
    .LONG_CYCLES(L),
    .NUM_COLORS(NC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .btn_n(btn_n),
    .color(color),
    .press_pulse(press_pulse),
    .long_pulse(long_pulse),
    .btn_level(btn_level),
    .red_led(red_led),
    .green_led(green_led),
    .blue_led(blue_led)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [2:0] leds_of(input int c);
    case (c)
      0:       return 3'b100;
      1:       return 3'b010;
      2:       return 3'b001;
      default: return 3'b000;
    endcase
  endfunction

  // Output side of the scoreboard: every strobe must match the oldest expected event.
  always @(negedge clk) begin
    if (press_pulse || long_pulse) begin
      check_val("both_pulses", {31'd0, press_pulse & long_pulse}, 32'd0);
      if (sb.size() == 0) begin
        check_val("spurious_pulse", {30'd0, press_pulse, long_pulse}, 32'd0);
      end else begin
        ev_t e;
        e = sb.pop_front();
        check_val("pulse_kind", {31'd0, long_pulse}, {31'd0, e.is_long});
        check_val("pulse_cycle", cyc, e.cyc);
        check_val("pulse_color", {29'd0, color}, {29'd0, e.color});
        check_val("pulse_leds", {29'd0, red_led, green_led, blue_led}, {29'd0, leds_of(int'(e.color))});
      end
    end
  end

  // Pin goes low right after an edge; btn_level must rise exactly D+2 edges later.
  task automatic check_level_rise(input int t0);
    repeat (D + 1) @(posedge clk);
    @(negedge clk);
    check_val("lvl_before", {31'd0, btn_level}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    check_val("lvl_after", {31'd0, btn_level}, 32'd1);
    check_val("lvl_cycle", cyc - t0, D + 2);
  endtask

  task automatic do_press(input int n);
    int  t0;
    ev_t e;
    @(posedge clk);
    #1;
    btn_n = 1'b0;
    t0 = cyc;
    if (n > L) begin
      e.is_long = 1'b1;
      e.cyc     = t0 + 3 + D + L;
      exp_color = 0;
    end else begin
      e.is_long = 1'b0;
      e.cyc     = t0 + n + 3 + D;
      exp_color = (exp_color == NC - 1) ? 0 : exp_color + 1;
    end
    e.color = 3'(exp_color);
    sb.push_back(e);
    check_level_rise(t0);
    repeat (n - D - 2) @(posedge clk);
    #1;
    btn_n = 1'b1;
    repeat (D + 12) @(posedge clk);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_val("rst_color", {29'd0, color}, 32'd0);
    check_val("rst_leds", {29'd0, red_led, green_led, blue_led}, 32'b100);
    check_val("rst_pulses", {30'd0, press_pulse, long_pulse}, 32'd0);
    check_val("rst_level", {31'd0, btn_level}, 32'd0);

    // Short press 0 -> 1, then 1 -> 2, then wrap sequence 0, 1, 2.
    do_press(10);
    check_val("short_green", {31'd0, green_led}, 32'd1);
    do_press(9);
    for (int i = 0; i < 3; i++) do_press(8 + i);
    check_val("wrap_color", {29'd0, color}, 32'd2);

    // Bounce shorter than the debounce window.
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      btn_n = ((i / 2) % 2) ? 1'b1 : 1'b0;
      @(negedge clk);
      check_val("bounce_level", {31'd0, btn_level}, 32'd0);
    end
    btn_n = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    check_val("bounce_color", {29'd0, color}, 32'd2);

    // Long press from colour 2; its release must stay silent.
    do_press(40);
    check_val("long_color", {29'd0, color}, 32'd0);
    check_val("long_red", {31'd0, red_led}, 32'd1);

    // Reset in HOLD with the button still held.
    do_press(10);
    begin
      int  t1;
      ev_t e;
      @(posedge clk);
      #1;
      btn_n = 1'b0;
      repeat (12) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      t1 = cyc;
      exp_color = 0;
      @(negedge clk);
      check_val("midrst_color", {29'd0, color}, 32'd0);
      check_val("midrst_leds", {29'd0, red_led, green_led, blue_led}, 32'b100);
      check_val("midrst_level", {31'd0, btn_level}, 32'd0);
      e.is_long = 1'b0;
      e.cyc     = t1 + 10 + 3 + D;
      e.color   = 3'd1;
      exp_color = 1;
      sb.push_back(e);
      check_level_rise(t1);
      repeat (10 - D - 2) @(posedge clk);
      #1;
      btn_n = 1'b1;
      repeat (D + 12) @(posedge clk);
    end
    @(negedge clk);
    check_val("final_color", {29'd0, color}, exp_color);
    check_val("sb_drained", sb.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/button_color_sel.md
Name: button_color_sel

Overview:
- Input-side counterpart to the board's RGB LED colour driver: reads a raw push-button and produces the colour selection instead of cycling it on a timer.
- Pipeline: synchronises and debounces the button, classifies each press as short or long, then steps or resets a colour index.
- Drives the one-hot red/green/blue LED enables directly.
- Sits between the board button pin and the RGB LED pins; runs on the 12 MHz system clock.

Parameters:
- DEBOUNCE_CYCLES, 120000, consecutive stable cycles required to accept a level change (10 ms at 12 MHz); minimum 2.
- LONG_CYCLES, 12000000, hold time in cycles, measured from the debounced press, that classifies a press as long (1 s); must exceed DEBOUNCE_CYCLES.
- NUM_COLORS, 3, number of colour indices; the index wraps NUM_COLORS-1 -> 0; range 2..8.

Ports:
- clk  input  1  system clock, 12 MHz.
- rst  input  1  reset, synchronous, active-high.
- btn_n  input  1  raw button pin, active-low (0 = pressed); asynchronous to clk.
- color  output  3  current colour index, 0..NUM_COLORS-1.
- press_pulse  output  1  one-cycle strobe when a short press completes.
- long_pulse  output  1  one-cycle strobe when a long press is recognised.
- btn_level  output  1  debounced button state (1 = pressed).
- red_led  output  1  high when color == 0.
- green_led  output  1  high when color == 1.
- blue_led  output  1  high when color == 2.

Behaviour:
- Reset: clk and rst are the block's single clock and reset. With rst high at a clk edge:
  - synchroniser flops load 1 (released);
  - debounce counter, hold counter, color, press_pulse, long_pulse and btn_level load 0;
  - FSM goes to IDLE;
  - red_led = 1, green_led = 0, blue_led = 0.
  - rst mid-press aborts the press and emits no pulse. After rst, a still-held button must debounce afresh and then counts as a new press.
- Synchroniser: two flops on btn_n; s = inverted output of the second flop (1 = pressed).
- Debounce:
  - Counter dcnt runs while s != btn_level and clears on any cycle where s == btn_level.
  - On the edge where dcnt == DEBOUNCE_CYCLES-1 and s != btn_level, btn_level <= s and dcnt <= 0.
  - A clean pin edge therefore reaches btn_level after 2 + DEBOUNCE_CYCLES clk edges.
  - Glitches shorter than DEBOUNCE_CYCLES never change btn_level.
- FSM, driven by btn_level:
  - IDLE: on btn_level rising, go to HOLD and set hcnt = 0.
  - HOLD: hcnt increments each cycle.
    - btn_level falls before hcnt reaches LONG_CYCLES-1: next cycle press_pulse = 1, color <= (color == NUM_COLORS-1) ? 0 : color+1, go to IDLE.
    - hcnt == LONG_CYCLES-1 while still pressed: next cycle long_pulse = 1, color <= 0, go to LATCH.
  - LATCH: wait for btn_level to fall, then go to IDLE. No pulse on release. No auto-repeat.
- Pulse rules: press_pulse and long_pulse are registered, exactly one cycle wide, and never high in the same cycle. color updates on the same edge the pulse asserts.
- LED outputs: red_led, green_led and blue_led are registered, one-hot decodes of color, updated on the same edge as color. Indices >= 3 (when NUM_COLORS > 3) drive all LEDs low.
- Widths: hcnt is $clog2(LONG_CYCLES) bits; dcnt is $clog2(DEBOUNCE_CYCLES) bits. Neither counter wraps: hcnt stops counting in LATCH.

Test Plan (sim params DEBOUNCE_CYCLES=4, LONG_CYCLES=20, NUM_COLORS=3):
- Reset: hold rst 2 cycles with btn_n=1 -> color=0, red_led=1, green_led=0, blue_led=0, all pulses 0, btn_level=0.
- Short press: btn_n low 10 cycles, then high -> btn_level rises 6 edges after the falling pin edge; press_pulse for one cycle after the debounced release; color 0->1; green_led=1.
- Wrap-around: three short presses starting from color=2 -> color sequence 0, 1, 2; blue_led=0 after the first press; exactly three press_pulse strobes.
- Bounce rejection: btn_n toggles every 2 cycles for 20 cycles, then stays high -> btn_level stays 0; no pulses; color unchanged.
- Long press: btn_n low 40 cycles from color=2 -> long_pulse exactly once, when hcnt reaches 19; color=0; release produces no press_pulse.
- Reset mid-press: rst pulsed while in HOLD with the button still held -> no pulse, color=0; press_pulse appears only after a fresh debounce, the release, and a second release-timed completion.
